instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  IF stage of the 5-stage MIPS pipeline: owns the PC, fetches from instruction memory over a
//  req/ack handshake and loads the IF/ID register whose opcode/func fields feed the control unit.
//  Applies control-unit redirects (pcSrc) and hazard stalls; flushes with the NOP opcode 6'b000001.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value after reset
//  NOP_INSTR  32'h0400_0000  bubble word (opcode 6'b000001, all else 0); decodes as NOP in CU
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst            in   1   asynchronous, active-high reset
//  pcSrc          in   2   00 seq (PC+4), 01 branch taken, 10 jump, 11 treated as 00
//  branch_target  in   32  branch target from ID, used when pcSrc==01
//  jump_index     in   26  J-type index from ID, used when pcSrc==10
//  stall          in   1   hazard unit: hold IF/ID and PC
//  imem_req       out  1   fetch request, held until imem_ack
//  imem_addr      out  32  word-aligned fetch address (== pc)
//  imem_ack       in   1   rdata valid this cycle; 1..N cycle latency
//  imem_rdata     in   32  fetched instruction
//  if_id_instr    out  32  IF/ID instruction
//  if_id_pc4      out  32  IF/ID PC+4 of that instruction
//  if_id_valid    out  1   IF/ID holds a real instruction (0 = bubble)
//  opcode         out  6   if_id_instr[31:26], to CU opcode
//  func           out  6   if_id_instr[5:0], to CU funcIn
// BEHAVIOUR
//  Reset (async): pc=RESET_PC, state=S_REQ, if_id_instr=NOP_INSTR, if_id_pc4=0, if_id_valid=0,
//   skid empty; imem_req rises first cycle after rst deasserts.
//  redirect = (pcSrc==01)|(pcSrc==10); next_target = 01: branch_target,
//   10: {if_id_pc4[31:28], jump_index, 2'b00}.
//  FSM S_REQ: imem_req=1, imem_addr=pc.
//   - redirect: pc<=next_target; IF/ID<=NOP_INSTR, valid 0; any ack this cycle discarded;
//     an outstanding request that acks later is also discarded (drop flag set until ack).
//   - else ack & !stall: IF/ID<=rdata, pc4<=pc+4, valid 1; pc<=pc+4.
//   - else ack & stall: capture rdata/pc+4 in skid; pc<=pc+4; go S_HOLD; IF/ID unchanged.
//   - else !ack & !stall: IF/ID<=NOP_INSTR, valid 0 (bubble); pc unchanged.
//   - else (!ack & stall): hold everything.
//  FSM S_HOLD: imem_req=0.
//   - redirect: drop skid; pc<=next_target; IF/ID<=NOP_INSTR, valid 0; go S_REQ.
//   - else !stall: IF/ID<=skid, valid 1; go S_REQ. else hold.
//  Priority: rst > redirect > stall > ack. Redirect overrides stall (control hazard wins).
//  Latency: ack at cycle t -> IF/ID valid at t+1 (no stall). Throughput 1 instr/cycle with 1-cycle ack.
//  pc arithmetic mod 2^32 (0xFFFF_FFFC + 4 -> 0); pc[1:0] always 00 (targets forced aligned).
//  Redirect while drop flag set: new target fetched only after stale ack; imem_req stays high.
//  imem_addr must not change while imem_req=1 and ack not seen, except across a discard.
// STRUCTURE
//  Shared package mips_pkg: opcode constants (LW, SW, BEQ, BNE, J, RTYPE, NOPE), PCSRC_SEQ/
//   PCSRC_BR/PCSRC_J encodings, NOP_INSTR, fetch state enum {S_REQ, S_HOLD}.
//  One sub-module: if_id_reg (instr/pc4/valid with load, flush, hold; reset to NOP_INSTR).
//  FSM, pc register, skid buffer and drop flag live in the top.
// TESTING
//  1 Reset, 1-cycle ack, words 0x8C010004,0x00221820 -> opcode 100011 then 000000/func 100000,
//    imem_addr 0,4,8; if_id_pc4 4,8.
//  2 pcSrc=01, branch_target=0x40 while ack pending -> IF/ID=0x04000000 valid 0, stale data
//    dropped, next imem_addr=0x40.
//  3 pcSrc=10, jump_index=0x10, if_id_pc4=0x1000_0008 -> imem_addr=0x1000_0040, bubble inserted.
//  4 stall 3 cycles during ack -> state S_HOLD, imem_req 0, IF/ID unchanged; release -> skid word
//    in IF/ID next cycle, no instruction lost/duplicated.
//  5 3-cycle ack latency, no stall -> two bubbles (opcode 000001, valid 0) then instruction.
//  6 rst asserted mid-fetch (pc=0x20) -> immediate pc=0, valid 0; redirect+stall same cycle -> redirect wins.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, PC-source encodings, the bubble word
// and the fetch-stage state encoding.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_NOPE  = 6'b000001;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_J   = 2'b10;

    // Opcode NOPE with every other field zero; the control unit decodes it as a no-op.
    localparam logic [31:0] NOP_INSTR = {OP_NOPE, 26'd0};

    typedef enum logic {
        S_REQ,
        S_HOLD
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction, its PC+4 and a valid bit, with flush,
// load and hold (flush wins over load).
module if_id_reg #(
    parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] instr_d,
    input  logic [31:0] pc4_d,
    output logic [31:0] instr,
    output logic [31:0] pc4,
    output logic        valid
);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr <= NOP_INSTR;
            pc4   <= 32'd0;
            valid <= 1'b0;
        end else if (flush) begin
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (load) begin
            instr <= instr_d;
            pc4   <= pc4_d;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// MIPS IF stage: PC, req/ack fetch FSM with a one-entry skid buffer for stalls,
// redirect handling with stale-response dropping, and the IF/ID register.
module instr_fetch_unit import mips_pkg::*; #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  pcSrc,
    input  logic [31:0] branch_target,
    input  logic [25:0] jump_index,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [5:0]  opcode,
    output logic [5:0]  func
);

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next, pc_plus4, next_target;
    logic [31:0]  skid_instr, skid_pc4;
    logic         skid_load;
    logic         drop, drop_next;
    logic         redirect;
    logic         ifid_load, ifid_flush;
    logic [31:0]  ifid_instr_d, ifid_pc4_d;

    assign pc_plus4  = pc + 32'd4;
    assign redirect  = (pcSrc == PCSRC_BR) || (pcSrc == PCSRC_J);
    assign imem_req  = (state == S_REQ) && !rst;
    assign imem_addr = pc;

    always_comb begin
        case (pcSrc)
            PCSRC_BR: next_target = branch_target & 32'hFFFF_FFFC;
            PCSRC_J:  next_target = {if_id_pc4[31:28], jump_index, 2'b00};
            default:  next_target = pc_plus4;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_next   = state;
        pc_next      = pc;
        drop_next    = drop;
        skid_load    = 1'b0;
        ifid_load    = 1'b0;
        ifid_flush   = 1'b0;
        ifid_instr_d = imem_rdata;
        ifid_pc4_d   = pc_plus4;
        case (state)
            S_REQ: begin
                // A request left in flight by a redirect stays stale until its ack arrives.
                drop_next = (drop || redirect) && !imem_ack;
                if (redirect) begin
                    pc_next    = next_target;
                    ifid_flush = 1'b1;
                end else if (drop) begin
                    ifid_flush = !stall;
                end else if (imem_ack && !stall) begin
                    ifid_load = 1'b1;
                    pc_next   = pc_plus4;
                end else if (imem_ack) begin
                    skid_load  = 1'b1;
                    pc_next    = pc_plus4;
                    state_next = S_HOLD;
                end else if (!stall) begin
                    ifid_flush = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_next    = next_target;
                    ifid_flush = 1'b1;
                    state_next = S_REQ;
                end else if (!stall) begin
                    ifid_load    = 1'b1;
                    ifid_instr_d = skid_instr;
                    ifid_pc4_d   = skid_pc4;
                    state_next   = S_REQ;
                end
            end
            default: state_next = S_REQ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_REQ;
            pc    <= RESET_PC;
            drop  <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            drop  <= drop_next;
        end
    end

    // NOTE: skid data needs no reset; it is only read in S_HOLD, after skid_load wrote it.
    always_ff @(posedge clk) begin
        if (skid_load) begin
            skid_instr <= imem_rdata;
            skid_pc4   <= pc_plus4;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk     (clk),
        .rst     (rst),
        .load    (ifid_load),
        .flush   (ifid_flush),
        .instr_d (ifid_instr_d),
        .pc4_d   (ifid_pc4_d),
        .instr   (if_id_instr),
        .pc4     (if_id_pc4),
        .valid   (if_id_valid)
    );

    assign opcode = if_id_instr[31:26];
    assign func   = if_id_instr[5:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, sequential fetch, branch/jump redirects,
// stall skid, multi-cycle ack, async reset, wraparound and redirect-during-drop.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0400_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  pcSrc;
    logic [31:0] branch_target;
    logic [25:0] jump_index;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [5:0]  opcode;
    logic [5:0]  func;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .pcSrc         (pcSrc),
        .branch_target (branch_target),
        .jump_index    (jump_index),
        .stall         (stall),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid),
        .opcode        (opcode),
        .func          (func)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] src, input logic [31:0] bt, input logic st,
                         input logic ack, input logic [31:0] rdata);
        pcSrc         = src;
        branch_target = bt;
        stall         = st;
        imem_ack      = ack;
        imem_rdata    = rdata;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(2'b00, 32'h0, 1'b0, 1'b0, 32'h0);
        jump_index = 26'h0;
        tick();
        tick();
        checks++; if (if_id_instr !== NOP) begin errors++; $display("FAIL rst_instr got %h want %h", if_id_instr, NOP); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", if_id_valid); end
        checks++; if (if_id_pc4 !== 32'h0) begin errors++; $display("FAIL rst_pc4 got %h want 0", if_id_pc4); end
        checks++; if (opcode !== 6'b000001) begin errors++; $display("FAIL rst_opcode got %b want 000001", opcode); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", imem_req); end
        rst = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_req_rise got %b want 1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h want 0", imem_addr); end
    endtask

    task automatic test_sequential();
        drive(2'b00, 32'h0, 1'b0, 1'b1, 32'h8C01_0004);
        tick();
        checks++; if (if_id_instr !== 32'h8C01_0004) begin errors++; $display("FAIL seq1_instr got %h want 8c010004", if_id_instr); end
        checks++; if (opcode !== 6'b100011) begin errors++; $display("FAIL seq1_opcode got %b want 100011", opcode); end
        checks++; if (if_id_pc4 !== 32'h4) begin errors++; $display("FAIL seq1_pc4 got %h want 4", if_id_pc4); end
        checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL seq1_valid got %b want 1", if_id_valid); end
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL seq1_addr got %h want 4", imem_addr); end
        drive(2'b00, 32'h0, 1'b0, 1'b1, 32'h0022_1820);
        tick();
        checks++; if (opcode !== 6'b000000) begin errors++; $display("FAIL seq2_opcode got %b want 000000", opcode); end
        checks++; if (func !== 6'b100000) begin errors++; $display("FAIL seq2_func got %b want 100000", func); end
        checks++; if (if_id_pc4 !== 32'h8) begin errors++; $display("FAIL seq2_pc4 got %h want 8", if_id_pc4); end
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL seq2_addr got %h want 8", imem_addr); end
        drive(2'b00, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL seq3_bubble got %b want 0", if_id_valid); end
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL seq3_addr_hold got %h want 8", imem_addr); end
    endtask

    task automatic test_branch();
        drive(2'b01, 32'h40, 1'b0, 1'b0, 32'h0);
        tick();
        checks++; if (if_id_instr !== NOP) begin errors++; $display("FAIL br_instr got %h want %h", if_id_instr, NOP); end
        checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL br_addr got %h want 40", imem_addr); end
        drive(2'b00, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        tick();
        checks++; if (if_id_instr !== NOP) begin errors++; $display("FAIL br_stale_instr got %h want %h", if_id_instr, NOP); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL br_stale_valid got %b want 0", if_id_valid); end
        checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL br_stale_addr got %h want 40", imem_addr); end
        drive(2'b00, 32'h0, 1'b0, 1'b1, 32'h8C02_0000);
        tick();
        checks++; if (if_id_instr !== 32'h8C02_0000) begin errors++; $display("FAIL br_fetch_instr got %h want 8c020000", if_id_instr); end
        checks++; if (if_id_pc4 !== 32'h44) begin errors++; $display("FAIL br_fetch_pc4 got %h want 44", if_id_pc4); end
    endtask

    task automatic test_jump();
        drive(2'b01, 32'h1000_0004, 1'b0, 1'b1, 32'h5555_5555);
        tick();
        drive(2'b00, 32'h0, 1'b0, 1'b1, 32'h0000_0020);
        tick();
        checks++; if (if_id_pc4 !== 32'h1000_0008) begin errors++; $display("FAIL j_setup_pc4 got %h want 10000008", if_id_pc4); end
        drive(2'b10, 32'h0, 1'b0, 1'b1, 32'h1111_1111);
        jump_index = 26'h10;
        tick();
        jump_index = 26'h0;
        checks++; if (imem_addr !== 32'h1000_0040) begin errors++; $display("FAIL j_addr got %h want 10000040", imem_addr); end
        checks++; if (if_id_instr !== NOP) begin errors++; $display("FAIL j_bubble got %h want %h", if_id_instr, NOP); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL j_valid got %b want 0", if_id_valid); end
    endtask

    task automatic test_stall();
        drive(2'b00, 32'h0, 1'b0, 1'b1, 32'h8C03_0008);
        tick();
        drive(2'b00, 32'h0, 1'b1, 1'b1, 32'hAC04_0010);
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL st_req got %b want 0", imem_req); end
        checks++; if (if_id_instr !== 32'h8C03_0008) begin errors++; $display("FAIL st_hold_instr got %h want 8c030008", if_id_instr); end
        checks++; if (imem_addr !== 32'h1000_0048) begin errors++; $display("FAIL st_addr got %h want 10000048", imem_addr); end
        drive(2'b00, 32'h0, 1'b1, 1'b0, 32'h0);
        tick();
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL st_req3 got %b want 0", imem_req); end
        checks++; if (if_id_pc4 !== 32'h1000_0044) begin errors++; $display("FAIL st_hold_pc4 got %h want 10000044", if_id_pc4); end
        drive(2'b00, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        checks++; if (if_id_instr !== 32'hAC04_0010) begin errors++; $display("FAIL st_skid_instr got %h want ac040010", if_id_instr); end
        checks++; if (if_id_pc4 !== 32'h1000_0048) begin errors++; $display("FAIL st_skid_pc4 got %h want 10000048", if_id_pc4); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL st_req_back got %b want 1", imem_req); end
        drive(2'b00, 32'h0, 1'b0, 1'b1, 32'h00A6_2020);
        tick();
        checks++; if (if_id_pc4 !== 32'h1000_004C) begin errors++; $display("FAIL st_next_pc4 got %h want 1000004c", if_id_pc4); end
    endtask

    task automatic test_latency();
        drive(2'b00, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        checks++; if (opcode !== 6'b000001) begin errors++; $display("FAIL lat_b1_opcode got %b want 000001", opcode); end
        tick();
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL lat_b2_valid got %b want 0", if_id_valid); end
        checks++; if (imem_addr !== 32'h1000_004C) begin errors++; $display("FAIL lat_addr_hold got %h want 1000004c", imem_addr); end
        drive(2'b00, 32'h0, 1'b0, 1'b1, 32'h8C05_0000);
        tick();
        checks++; if (if_id_instr !== 32'h8C05_0000) begin errors++; $display("FAIL lat_instr got %h want 8c050000", if_id_instr); end
        checks++; if (if_id_pc4 !== 32'h1000_0050) begin errors++; $display("FAIL lat_pc4 got %h want 10000050", if_id_pc4); end
    endtask

    task automatic test_reset_mid();
        drive(2'b01, 32'h20, 1'b0, 1'b1, 32'h0);
        tick();
        checks++; if (imem_addr !== 32'h20) begin errors++; $display("FAIL rm_setup_addr got %h want 20", imem_addr); end
        drive(2'b00, 32'h0, 1'b0, 1'b1, 32'h8C09_0000);
        #2 rst = 1'b1;
        #1;
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rm_addr got %h want 0", imem_addr); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL rm_valid got %b want 0", if_id_valid); end
        tick();
        rst = 1'b0;
        drive(2'b00, 32'h0, 1'b0, 1'b1, 32'h8C06_0000);
        tick();
        checks++; if (if_id_pc4 !== 32'h4) begin errors++; $display("FAIL rm_refetch_pc4 got %h want 4", if_id_pc4); end
        drive(2'b01, 32'h80, 1'b1, 1'b1, 32'h7777_7777);
        tick();
        checks++; if (imem_addr !== 32'h80) begin errors++; $display("FAIL rs_addr got %h want 80", imem_addr); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rs_req got %b want 1", imem_req); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL rs_valid got %b want 0", if_id_valid); end
        drive(2'b00, 32'h0, 1'b1, 1'b1, 32'h1234_5678);
        tick();
        drive(2'b01, 32'hC0, 1'b1, 1'b0, 32'h0);
        tick();
        checks++; if (imem_addr !== 32'hC0) begin errors++; $display("FAIL hr_addr got %h want c0", imem_addr); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL hr_req got %b want 1", imem_req); end
    endtask

    task automatic test_wrap_and_drop();
        drive(2'b01, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0);
        tick();
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_align got %h want fffffffc", imem_addr); end
        drive(2'b00, 32'h0, 1'b0, 1'b1, 32'h0800_0000);
        tick();
        checks++; if (if_id_pc4 !== 32'h0) begin errors++; $display("FAIL wr_pc4 got %h want 0", if_id_pc4); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wr_addr got %h want 0", imem_addr); end
        checks++; if (opcode !== 6'b000010) begin errors++; $display("FAIL wr_opcode got %b want 000010", opcode); end
        drive(2'b01, 32'h100, 1'b0, 1'b0, 32'h0);
        tick();
        drive(2'b01, 32'h200, 1'b0, 1'b0, 32'h0);
        tick();
        checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL dr_addr got %h want 200", imem_addr); end
        drive(2'b00, 32'h0, 1'b0, 1'b1, 32'hBAD0_BAD0);
        tick();
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL dr_stale_valid got %b want 0", if_id_valid); end
        drive(2'b00, 32'h0, 1'b0, 1'b1, 32'h8C07_0000);
        tick();
        checks++; if (if_id_instr !== 32'h8C07_0000) begin errors++; $display("FAIL dr_instr got %h want 8c070000", if_id_instr); end
        checks++; if (if_id_pc4 !== 32'h204) begin errors++; $display("FAIL dr_pc4 got %h want 204", if_id_pc4); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_stall();
        test_latency();
        test_reset_mid();
        test_wrap_and_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
